// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the J*sigma multiply datapath.
package matmul_pkg;

  localparam int DEF_VECTOR_WIDTH = 8;
  localparam int DEF_N            = 4;
  localparam int COL_IDX_W        = $clog2(DEF_VECTOR_WIDTH);

  typedef logic signed [DEF_N-1:0] j_elem_t;

  typedef enum logic {
    IDLE,
    STREAM
  } loader_state_e;

endpackage

// File: rtl/j_column_buffer.sv
// One J column register bank: rows are written one at a time, and a full flag
// marks the column as ready to drain. The loader keeps two of these for ping-pong.
module j_column_buffer
  import matmul_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int N            = DEF_N
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(VECTOR_WIDTH)-1:0] wr_row,
  input  logic signed [N-1:0]             wr_data,
  input  logic                            set_full,
  input  logic                            clear,
  output logic signed [N-1:0]             data [VECTOR_WIDTH],
  output logic                            full
);

  // Row storage; reset clears the bank so an empty loader presents zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < VECTOR_WIDTH; r++) begin
        data[r] <= '0;
      end
    end else if (wr_en) begin
      data[wr_row] <= wr_data;
    end
  end

  // Full flag: set when the last row lands, cleared when the column is consumed.
  // The loader never sets and clears the same bank in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/j_column_loader.sv
// Deserialises a stream of J elements into whole columns using a ping-pong
// pair of column buffers, and presents each column with its index and the
// frame's latched sigma vector over a valid/ready handshake.
module j_column_loader
  import matmul_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int N            = DEF_N
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sigma_valid,
  output logic                            sigma_ready,
  input  logic [VECTOR_WIDTH-1:0]         sigma_in,
  input  logic                            elem_valid,
  output logic                            elem_ready,
  input  logic signed [N-1:0]             elem_data,
  output logic                            col_valid,
  input  logic                            col_ready,
  output logic signed [N-1:0]             J_Column [VECTOR_WIDTH],
  output logic [$clog2(VECTOR_WIDTH)-1:0] col_index,
  output logic [VECTOR_WIDTH-1:0]         sigma_vector,
  output logic                            frame_done
);

  localparam int                IDX_W    = $clog2(VECTOR_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VECTOR_WIDTH - 1);
  localparam logic [IDX_W:0]    COLS_MAX = (IDX_W + 1)'(VECTOR_WIDTH);

  loader_state_e    state;
  logic             fill_ptr;
  logic             drain_ptr;
  logic [IDX_W-1:0] row_cnt;
  logic [IDX_W:0]   cols_filled;

  logic             elem_hs;
  logic             col_hs;
  logic             last_row;
  logic [1:0]       buf_full;
  logic [1:0]       buf_wr_en;
  logic [1:0]       buf_set_full;
  logic [1:0]       buf_clear;
  logic             full0;
  logic             full1;

  logic signed [N-1:0] buf0_data [VECTOR_WIDTH];
  logic signed [N-1:0] buf1_data [VECTOR_WIDTH];

  assign buf_full = {full1, full0};

  // Ready/valid are decoded purely from registers, so a drain in this cycle
  // only frees the fill side from the next cycle on.
  assign elem_ready = (state == STREAM) && !buf_full[fill_ptr] && (cols_filled < COLS_MAX);
  assign col_valid  = buf_full[drain_ptr];
  assign elem_hs    = elem_valid && elem_ready;
  assign col_hs     = col_valid && col_ready;
  assign last_row   = (row_cnt == LAST_IDX);

  // Route write, fill-complete and drain strobes to the addressed bank.
  always_comb begin
    buf_wr_en    = '0;
    buf_set_full = '0;
    buf_clear    = '0;
    if (elem_hs) begin
      buf_wr_en[fill_ptr]    = 1'b1;
      buf_set_full[fill_ptr] = last_row;
    end
    if (col_hs) begin
      buf_clear[drain_ptr] = 1'b1;
    end
  end

  // Present the drain-side bank; it cannot change while it is full.
  always_comb begin
    for (int r = 0; r < VECTOR_WIDTH; r++) begin
      J_Column[r] = drain_ptr ? buf1_data[r] : buf0_data[r];
    end
  end

  j_column_buffer #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .N            (N)
  ) u_buf0 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_en[0]),
    .wr_row   (row_cnt),
    .wr_data  (elem_data),
    .set_full (buf_set_full[0]),
    .clear    (buf_clear[0]),
    .data     (buf0_data),
    .full     (full0)
  );

  j_column_buffer #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .N            (N)
  ) u_buf1 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_en[1]),
    .wr_row   (row_cnt),
    .wr_data  (elem_data),
    .set_full (buf_set_full[1]),
    .clear    (buf_clear[1]),
    .data     (buf1_data),
    .full     (full1)
  );

  // Frame sequencer: sigma capture in IDLE, fill/drain bookkeeping in STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sigma_ready  <= 1'b0;
      sigma_vector <= '0;
      fill_ptr     <= 1'b0;
      drain_ptr    <= 1'b0;
      row_cnt      <= '0;
      cols_filled  <= '0;
      col_index    <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          sigma_ready <= 1'b1;
          if (sigma_valid && sigma_ready) begin
            sigma_vector <= sigma_in;
            sigma_ready  <= 1'b0;
            state        <= STREAM;
          end
        end

        STREAM: begin
          sigma_ready <= 1'b0;

          if (elem_hs) begin
            if (last_row) begin
              row_cnt     <= '0;
              fill_ptr    <= ~fill_ptr;
              cols_filled <= cols_filled + 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end

          if (col_hs) begin
            drain_ptr <= ~drain_ptr;
            if (col_index == LAST_IDX) begin
              // Every column has been filled by now, so nothing is in flight
              // on the fill side; restart all counters for the next frame.
              col_index   <= '0;
              frame_done  <= 1'b1;
              state       <= IDLE;
              sigma_ready <= 1'b1;
              cols_filled <= '0;
              row_cnt     <= '0;
              fill_ptr    <= 1'b0;
              drain_ptr   <= 1'b0;
            end else begin
              col_index <= col_index + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j_column_loader.sv
// Directed bench for j_column_loader with VECTOR_WIDTH=8, N=4.
module tb_j_column_loader;

  logic              clk;
  logic              rst;
  logic              sigma_valid;
  logic              sigma_ready;
  logic [7:0]        sigma_in;
  logic              elem_valid;
  logic              elem_ready;
  logic [3:0]        elem_data;
  logic              col_valid;
  logic              col_ready;
  logic signed [3:0] j_column [8];
  logic [2:0]        col_index;
  logic [7:0]        sigma_vector;
  logic              frame_done;

  int tests = 0;
  int fails = 0;

  j_column_loader #(
    .VECTOR_WIDTH (8),
    .N            (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sigma_valid  (sigma_valid),
    .sigma_ready  (sigma_ready),
    .sigma_in     (sigma_in),
    .elem_valid   (elem_valid),
    .elem_ready   (elem_ready),
    .elem_data    (elem_data),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .J_Column     (j_column),
    .col_index    (col_index),
    .sigma_vector (sigma_vector),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_elem(input int c, input int r);
    return 4'((c + r) % 16);
  endfunction

  // Offer sig at the current negedge, wait (bounded) for the handshake.
  task automatic send_sigma(input logic [7:0] sig);
    int k;
    sigma_valid = 1'b1;
    sigma_in    = sig;
    k = 0;
    while (!sigma_ready && k < 20) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("sigma_accept_wait", sigma_ready, 1);
    @(posedge clk); @(negedge clk);
    sigma_valid = 1'b0;
    #1;
    check("sigma_latched", sigma_vector, sig);
    check("sigma_ready_stream", sigma_ready, 0);
  endtask

  // One full frame: producer pattern (c+r)%16, optional bursty producer,
  // optional consumer stall after column 0, optional timing and sigma-holdoff checks.
  task automatic run_frame(input logic [7:0] sig, input bit bursty, input int stall_cycles,
                           input bit timing_chk, input bit sig2);
    int elems, cols, cyc, t0, stall_left;
    bit stall_on;
    send_sigma(sig);
    elems = 0; cols = 0; cyc = 0; t0 = -1;
    stall_left = stall_cycles; stall_on = 1'b0;
    while (cols < 8 && cyc < 1000) begin
      elem_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      elem_data  = (elems < 64) ? exp_elem(elems / 8, elems % 8) : 4'h0;
      if (sig2) begin
        sigma_valid = 1'b1;
        sigma_in    = 8'h3C;
      end
      if (stall_left > 0 && (col_valid || stall_on)) begin
        stall_on  = 1'b1;
        col_ready = 1'b0;
      end else begin
        col_ready = 1'b1;
      end
      #1;
      check("sigma_hold", sigma_vector, sig);
      check("frame_done_low", frame_done, 0);
      if (sig2) check("sigma_held_off", sigma_ready, 0);
      if (!bursty && stall_cycles == 0 && elems < 64) check("elem_ready_sustained", elem_ready, 1);
      if (!col_ready) begin
        check("stall_valid", col_valid, 1);
        check("stall_index", col_index, 0);
        for (int r = 0; r < 8; r++) check("stall_data", $unsigned(j_column[r]), exp_elem(0, r));
        stall_left--;
        if (stall_left == 0) begin
          check("bp_elems", elems, 16);
          check("bp_elem_ready", elem_ready, 0);
        end
      end
      if (col_valid && col_ready) begin
        check("col_index", col_index, cols);
        for (int r = 0; r < 8; r++) check("col_data", $unsigned(j_column[r]), exp_elem(cols, r));
        check("col_complete", elems >= 8 * (cols + 1), 1);
        if (timing_chk) check("col_timing", cyc - t0, 8 * cols + 8);
        cols++;
      end
      if (elem_valid && elem_ready) begin
        if (t0 < 0) t0 = cyc;
        elems++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("frame_cols", cols, 8);
    sigma_valid = 1'b0;
    elem_valid  = 1'b0;
    col_ready   = 1'b0;
    #1;
    check("frame_done_pulse", frame_done, 1);
    check("end_col_valid", col_valid, 0);
    check("end_elem_ready", elem_ready, 0);
    check("end_sigma_ready", sigma_ready, 1);
    check("end_col_index", col_index, 0);
    check("end_sigma_hold", sigma_vector, sig);
    check("end_elems", elems, 64);
    @(posedge clk); @(negedge clk);
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    int elems, k;
    rst = 1'b1;
    sigma_valid = 1'b0; sigma_in = '0;
    elem_valid = 1'b0; elem_data = '0; col_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sigma_ready", sigma_ready, 0);
    check("rst_elem_ready", elem_ready, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_col_index", col_index, 0);
    check("rst_sigma_vector", sigma_vector, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    #1;
    check("release_sigma_ready", sigma_ready, 0);
    @(negedge clk);
    check("idle_sigma_ready", sigma_ready, 1);

    // Basic frame
    run_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    // Backpressure: 30 stalled cycles after column 0 appears
    run_frame(8'h96, 1'b0, 30, 1'b0, 1'b0);
    // Bursty producer
    run_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
    // Frame boundary: 8'h3C offered throughout frame 1, used by frame 2
    run_frame(8'hA5, 1'b0, 0, 1'b0, 1'b1);
    run_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);

    // Reset mid-frame after 20 elements
    send_sigma(8'h77);
    elems = 0; k = 0;
    while (elems < 20 && k < 100) begin
      elem_valid = 1'b1;
      elem_data  = exp_elem(elems / 8, elems % 8);
      col_ready  = 1'b1;
      #1;
      if (elem_ready) elems++;
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("mid_elems", elems, 20);
    check("mid_col_index", col_index, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sigma_ready", sigma_ready, 0);
    check("mid_rst_elem_ready", elem_ready, 0);
    check("mid_rst_col_valid", col_valid, 0);
    check("mid_rst_col_index", col_index, 0);
    check("mid_rst_sigma_vector", sigma_vector, 0);
    check("mid_rst_frame_done", frame_done, 0);
    for (int r = 0; r < 8; r++) check("mid_rst_j_column", $unsigned(j_column[r]), 0);
    elem_valid = 1'b0;
    col_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset frame with continuous flow: sustained throughput and latency
    run_frame(8'h5A, 1'b0, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/j_column_loader.md
Name: j_column_loader

Overview:
- Producer side of the J·sigma multiply datapath: deserialises a stream of N-bit coupling elements into full VECTOR_WIDTH-element J columns.
- Presents each column, its index and the frame's latched sigma vector to the multiplier over a valid/ready handshake.
- Ping-pong double buffer so filling column c+1 overlaps consumption of column c; one frame = VECTOR_WIDTH columns.

Parameters:
- VECTOR_WIDTH, 8, spins per vector = elements per column = columns per frame (≥2).
- N, 4, bits per J element (signed two's complement, passed through untouched).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sigma_valid  in  1  sigma vector offered.
- sigma_ready  out  1  sigma accepted this cycle when valid&ready.
- sigma_in  in  VECTOR_WIDTH  spin vector for next frame.
- elem_valid  in  1  J element offered.
- elem_ready  out  1  element accepted when valid&ready.
- elem_data  in  N  J element, row-major within column: stream position c*VECTOR_WIDTH+r → J_Column[r] of column c.
- col_valid  out  1  full column presented.
- col_ready  in  1  multiplier consumes column when valid&ready.
- J_Column  out  N x [VECTOR_WIDTH] unpacked array, column data.
- col_index  out  $clog2(VECTOR_WIDTH)  index of presented column.
- sigma_vector  out  VECTOR_WIDTH  latched sigma, stable for whole frame.
- frame_done  out  1  one-cycle pulse after last column handshake.

Behaviour:
- Reset (async, any time, incl. mid-frame): FSM→IDLE; both buffers empty; fill/drain pointers, row/column counters = 0; sigma_ready=0 until first clock after release; elem_ready=0, col_valid=0, col_index=0, sigma_vector=0, J_Column all 0, frame_done=0. Partial columns are discarded.
- FSM IDLE: sigma_ready=1, elem_ready=0. On sigma handshake: latch sigma_in→sigma_vector, →STREAM.
- FSM STREAM: sigma_ready=0. elem_ready=1 iff fill buffer free AND columns_filled < VECTOR_WIDTH. Row counter increments per accepted element; at row VECTOR_WIDTH-1 the buffer is marked full, row counter wraps to 0, fill pointer toggles, columns_filled++.
- Output: col_valid=1 iff drain buffer full; J_Column/col_index driven from drain buffer, stable while col_valid&!col_ready. On handshake: buffer freed, drain pointer toggles, col_index++.
- Latency: column valid the cycle after its last element handshake (registered). Throughput: 1 element/cycle sustained when col_ready held high; no bubble between columns.
- Simultaneous fill-complete and drain of the other buffer in the same cycle: both take effect; elem_ready stays 1 next cycle.
- Both buffers full: elem_ready=0 until a column handshake; that handshake cycle does not itself raise elem_ready (registered flag; next cycle).
- Last column (col_index=VECTOR_WIDTH-1) handshake: frame_done=1 next cycle, counters cleared, col_index wraps to 0, →IDLE. sigma_vector holds its value until next sigma handshake.
- Extra elements beyond VECTOR_WIDTH*VECTOR_WIDTH are not accepted (elem_ready=0).
- sigma offered during STREAM: ignored, held off by sigma_ready=0.

Decomposition:
- Shared package matmul_pkg: COL_IDX_W = $clog2(VECTOR_WIDTH), j_elem_t (logic signed [N-1:0]), loader_state_e {IDLE, STREAM}.
- One sub-module natural: j_column_buffer (single column register bank with row write-enable, full flag); instantiated twice for ping-pong.

Test Plan:
- Basic frame (VW=8, N=4): sigma=8'hA5, 64 elements value (c+r)%16, col_ready=1 → 8 columns in order, column c row r = (c+r)%16, sigma_vector=8'hA5 throughout, frame_done pulse one cycle after column 7 handshake.
- Backpressure: col_ready=0 for 30 cycles after first column → elem_ready drops after 16 elements accepted; column 0 data/index stable throughout; release → columns 1..7 correct, no loss or duplication.
- Bursty producer: elem_valid random 50% → same column contents as the basic frame; col_valid only on complete columns.
- Frame boundary: sigma for frame 2 (8'h3C) offered during frame 1 → not accepted until IDLE; frame 2 uses 8'h3C, col_index restarts at 0.
- Reset mid-frame: assert rst after 20 elements → all outputs 0 immediately; new frame after release produces correct columns from element 0.
- Simultaneous fill/drain: col_ready=1, elem_valid=1 continuous → elem_ready never drops; column k valid exactly 8k+8 cycles after first element handshake.
